// File: rtl/code_epl_shiftreg_pkg.sv
// Shared baseband helpers: default constants, spacing clamp and counter width.
package code_epl_shiftreg_pkg;

    localparam int unsigned DEPTH_DEF     = 8;
    localparam int unsigned SPC_W_DEF     = 2;
    localparam int unsigned EPOCH_LEN_DEF = 1023;
    localparam int unsigned SPC_DEF_DEF   = 1;

    // Width of the chip index within one epoch.
    function automatic int unsigned cnt_width(input int unsigned epoch_len);
        return $clog2(epoch_len);
    endfunction

    // Effective tap distance: zero means one chip, and late must stay inside the register.
    function automatic int unsigned eff_spacing(input int unsigned spc, input int unsigned depth);
        int unsigned max_spc;
        max_spc = (depth - 1) / 2;
        if (spc == 0) begin
            return 1;
        end
        if (spc > max_spc) begin
            return max_spc;
        end
        return spc;
    endfunction

endpackage

// File: rtl/code_epl_shiftreg_epoch_counter.sv
// Chip index counter with wrap at EPOCH_LEN and a registered one-cycle epoch pulse.
module epoch_counter #(
    parameter int unsigned EPOCH_LEN = 1023,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap_pulse
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(EPOCH_LEN - 1);

    // Clear has priority over counting so a restart never emits a stale pulse.
    always_ff @(posedge clock or posedge sclr) begin
        if (sclr) begin
            cnt        <= '0;
            wrap_pulse <= 1'b0;
        end else if (clr) begin
            cnt        <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= inc && (cnt == LAST);
            if (inc) begin
                cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/code_epl_shiftreg.sv
// Code shift register with early/prompt/late taps, fill tracking and epoch counting.
module code_epl_shiftreg
    import code_epl_shiftreg_pkg::*;
#(
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned SPC_W     = SPC_W_DEF,
    parameter int unsigned EPOCH_LEN = EPOCH_LEN_DEF,
    parameter int unsigned SPC_DEF   = SPC_DEF_DEF
) (
    input  logic                                clock,
    input  logic                                sclr,
    input  logic                                enable,
    input  logic                                shiftin,
    input  logic                                sync,
    input  logic [SPC_W-1:0]                    spacing,
    output logic [DEPTH-1:0]                    q,
    output logic                                early,
    output logic                                prompt,
    output logic                                late,
    output logic                                valid,
    output logic [cnt_width(EPOCH_LEN)-1:0]     chip_cnt,
    output logic                                epoch
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W  = cnt_width(EPOCH_LEN);

    logic [SPC_W-1:0]  spacing_q;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic [FILL_W-1:0] fill_max;
    logic [IDX_W-1:0]  s;
    logic [IDX_W-1:0]  s2;
    int unsigned       s_int;
    logic              accept;

    assign accept = enable && !sync;

    // Tap distance only follows spacing_q, so an unsynced spacing change is invisible.
    always_comb begin
        s_int    = eff_spacing(32'(spacing_q), DEPTH);
        s        = IDX_W'(s_int);
        s2       = s << 1;
        fill_max = FILL_W'(2 * s_int + 1);
        fill_nxt = (fill < fill_max) ? fill + FILL_W'(1) : fill;
    end

    assign early  = q[0];
    assign prompt = q[s];
    assign late   = q[s2];

    always_ff @(posedge clock or posedge sclr) begin
        if (sclr) begin
            q         <= '0;
            fill      <= '0;
            valid     <= 1'b0;
            spacing_q <= SPC_W'(SPC_DEF);
        end else if (sync) begin
            q         <= '0;
            fill      <= '0;
            valid     <= 1'b0;
            spacing_q <= spacing;
        end else if (enable) begin
            q     <= {q[DEPTH-2:0], shiftin};
            fill  <= fill_nxt;
            valid <= (fill_nxt >= fill_max);
        end
    end

    epoch_counter #(
        .EPOCH_LEN (EPOCH_LEN),
        .CNT_W     (CNT_W)
    ) u_epoch_counter (
        .clock      (clock),
        .sclr       (sclr),
        .clr        (sync),
        .inc        (accept),
        .cnt        (chip_cnt),
        .wrap_pulse (epoch)
    );

endmodule

// File: tb/tb_code_epl_shiftreg.sv
// Directed bench for code_epl_shiftreg with DEPTH=8, EPOCH_LEN=4.
module tb_code_epl_shiftreg;

    logic       clock;
    logic       sclr;
    logic       enable;
    logic       shiftin;
    logic       sync;
    logic [1:0] spacing;
    logic [7:0] q;
    logic       early;
    logic       prompt;
    logic       late;
    logic       valid;
    logic [1:0] chip_cnt;
    logic       epoch;

    int checks   = 0;
    int failures = 0;

    code_epl_shiftreg #(
        .DEPTH     (8),
        .SPC_W     (2),
        .EPOCH_LEN (4),
        .SPC_DEF   (1)
    ) dut (
        .clock    (clock),
        .sclr     (sclr),
        .enable   (enable),
        .shiftin  (shiftin),
        .sync     (sync),
        .spacing  (spacing),
        .q        (q),
        .early    (early),
        .prompt   (prompt),
        .late     (late),
        .valid    (valid),
        .chip_cnt (chip_cnt),
        .epoch    (epoch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic shift(input logic b);
        @(negedge clock);
        sync    = 1'b0;
        enable  = 1'b1;
        shiftin = b;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic b);
        @(negedge clock);
        sync    = 1'b0;
        enable  = 1'b0;
        shiftin = b;
        @(posedge clock);
        #1;
    endtask

    task automatic do_sync(input logic [1:0] spc);
        @(negedge clock);
        sync    = 1'b1;
        enable  = 1'b0;
        spacing = spc;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        sclr = 1'b1; enable = 1'b0; sync = 1'b0; shiftin = 1'b0; spacing = 2'd1;
        #12;
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", q); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (chip_cnt !== 2'd0 || epoch !== 1'b0) begin failures++; $display("FAIL reset_cnt got=%0d/%b exp=0/0", chip_cnt, epoch); end
        checks++; if ({early, prompt, late} !== 3'b000) begin failures++; $display("FAIL reset_taps got=%b exp=000", {early, prompt, late}); end
        @(negedge clock);
        sclr = 1'b0;
        do_sync(2'd1);
        for (int i = 1; i <= 10; i++) begin
            shift(1'b1);
            if (i <= 3) begin
                checks++;
                if (valid !== (i == 3)) begin failures++; $display("FAIL reset_valid_rise shift=%0d got=%b exp=%b", i, valid, (i == 3)); end
            end
        end
        checks++; if (q !== 8'hFF) begin failures++; $display("FAIL ones_q got=%h exp=ff", q); end
        checks++; if ({early, prompt, late} !== 3'b111) begin failures++; $display("FAIL ones_taps got=%b exp=111", {early, prompt, late}); end
        checks++; if (chip_cnt !== 2'd2) begin failures++; $display("FAIL ones_cnt got=%0d exp=2", chip_cnt); end
    endtask

    task automatic test_taps;
        logic [4:0] pat;
        pat = 5'b00001;
        do_sync(2'd2);
        for (int i = 0; i < 5; i++) begin
            shift(pat[i]);
            if (i == 3) begin
                checks++; if (valid !== 1'b0) begin failures++; $display("FAIL taps_valid_early got=%b exp=0", valid); end
            end
        end
        checks++; if (q !== 8'h10) begin failures++; $display("FAIL taps_q got=%h exp=10", q); end
        checks++; if ({early, prompt, late} !== 3'b001) begin failures++; $display("FAIL taps_epl got=%b exp=001", {early, prompt, late}); end
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL taps_valid got=%b exp=1", valid); end
    endtask

    task automatic test_clamp;
        do_sync(2'd3);
        shift(1'b1);
        for (int i = 2; i <= 7; i++) begin
            shift(1'b0);
            if (i == 6) begin
                checks++; if (valid !== 1'b0) begin failures++; $display("FAIL clamp3_valid_early got=%b exp=0", valid); end
            end
        end
        checks++; if (q !== 8'h40) begin failures++; $display("FAIL clamp3_q got=%h exp=40", q); end
        checks++; if ({early, prompt, late} !== 3'b001) begin failures++; $display("FAIL clamp3_epl got=%b exp=001", {early, prompt, late}); end
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL clamp3_valid got=%b exp=1", valid); end
        do_sync(2'd0);
        shift(1'b1);
        checks++; if (early !== 1'b1) begin failures++; $display("FAIL clamp0_early got=%b exp=1", early); end
        shift(1'b0);
        checks++; if ({early, prompt, late} !== 3'b010) begin failures++; $display("FAIL clamp0_prompt got=%b exp=010", {early, prompt, late}); end
        shift(1'b0);
        checks++; if ({early, prompt, late, valid} !== 4'b0011) begin failures++; $display("FAIL clamp0_late got=%b exp=0011", {early, prompt, late, valid}); end
        spacing = 2'd3;
        shift(1'b0);
        checks++; if ({q, prompt, late, valid} !== {8'h08, 3'b001}) begin failures++; $display("FAIL nosync_spacing got=%h/%b exp=08/001", q, {prompt, late, valid}); end
    endtask

    task automatic test_epoch_wrap;
        logic [1:0] exp_seq [8];
        int         pulses;
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        pulses  = 0;
        do_sync(2'd1);
        for (int i = 0; i < 8; i++) begin
            shift(1'(i % 2));
            checks++;
            if (chip_cnt !== exp_seq[i]) begin failures++; $display("FAIL wrap_cnt idx=%0d got=%0d exp=%0d", i, chip_cnt, exp_seq[i]); end
            checks++;
            if (epoch !== (i == 3 || i == 7)) begin failures++; $display("FAIL wrap_epoch idx=%0d got=%b exp=%b", i, epoch, (i == 3 || i == 7)); end
            if (epoch === 1'b1) pulses++;
        end
        idle(1'b0);
        checks++; if (epoch !== 1'b0) begin failures++; $display("FAIL wrap_epoch_clear got=%b exp=0", epoch); end
        checks++; if (pulses != 2) begin failures++; $display("FAIL wrap_pulse_count got=%0d exp=2", pulses); end
    endtask

    task automatic test_hold;
        do_sync(2'd1);
        shift(1'b1);
        shift(1'b1);
        shift(1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'(i % 2 == 0));
            checks++;
            if (q !== 8'h06 || chip_cnt !== 2'd3 || valid !== 1'b1 || epoch !== 1'b0) begin
                failures++; $display("FAIL hold cyc=%0d got=%h/%0d/%b/%b exp=06/3/1/0", i, q, chip_cnt, valid, epoch);
            end
        end
    endtask

    task automatic test_sync_vs_enable;
        @(negedge clock);
        sync = 1'b1; enable = 1'b1; shiftin = 1'b1; spacing = 2'd1;
        @(posedge clock);
        #1;
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL syncen_q got=%h exp=00", q); end
        checks++; if (chip_cnt !== 2'd0 || valid !== 1'b0 || epoch !== 1'b0) begin failures++; $display("FAIL syncen_state got=%0d/%b/%b exp=0/0/0", chip_cnt, valid, epoch); end
        shift(1'b0);
        checks++; if (q !== 8'h00 || chip_cnt !== 2'd1) begin failures++; $display("FAIL syncen_drop got=%h/%0d exp=00/1", q, chip_cnt); end
    endtask

    task automatic test_reset_mid_epoch;
        do_sync(2'd2);
        shift(1'b1);
        shift(1'b1);
        checks++; if (chip_cnt !== 2'd2) begin failures++; $display("FAIL mid_pre_cnt got=%0d exp=2", chip_cnt); end
        @(negedge clock);
        enable = 1'b0;
        #2;
        sclr = 1'b1;
        #1;
        checks++;
        if (q !== 8'h00 || chip_cnt !== 2'd0 || valid !== 1'b0 || epoch !== 1'b0 || {early, prompt, late} !== 3'b000) begin
            failures++; $display("FAIL mid_async got=%h/%0d/%b/%b/%b exp=00/0/0/0/000", q, chip_cnt, valid, epoch, {early, prompt, late});
        end
        @(negedge clock);
        sclr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            shift(1'b1);
            checks++;
            if (epoch !== (i == 4)) begin failures++; $display("FAIL mid_epoch shift=%0d got=%b exp=%b", i, epoch, (i == 4)); end
            if (i == 1) begin
                checks++; if (chip_cnt !== 2'd1) begin failures++; $display("FAIL mid_cnt got=%0d exp=1", chip_cnt); end
            end
            if (i == 3) begin
                checks++; if (valid !== 1'b1) begin failures++; $display("FAIL mid_spc_default got=%b exp=1", valid); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_taps();
        test_clamp();
        test_epoch_wrap();
        test_hold();
        test_sync_vs_enable();
        test_reset_mid_epoch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
